// File: rtl/core_pkg.sv
// Shared definitions for the Wishbone-to-neuron-core sequencer: FSM encoding and
// the fixed control addresses recognised by the external address decoder.
package core_pkg;

  localparam int NUM_OF_SLICE = 8;

  localparam logic [31:0] DONE_PIC_ADDR      = 32'h3000_0840;
  localparam logic [31:0] CHOOSE_WEIGHT_BASE = 32'h3000_0800;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/core_wb_seq_if.sv
// Wishbone classic slave bus between the host and core_wb_seq.
interface core_wb_seq_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/core_rdata_mux.sv
// Read-data merge: timeout word, weight index, or OR of the selected slice words
// (a broadcast ORs every slice).
module core_rdata_mux #(
  parameter int NUM_OF_SLICE = 8
) (
  input  logic [32*NUM_OF_SLICE-1:0] i_slice_rdata,
  input  logic [NUM_OF_SLICE-1:0]    i_mask,
  input  logic                       i_spike,
  input  logic                       i_cw,
  input  logic                       i_tmo,
  input  logic [5:0]                 i_weight_sel,
  output logic [31:0]                o_rdata
);

  logic [31:0] w_or;

  always_comb begin
    w_or = '0;
    for (int k = 0; k < NUM_OF_SLICE; k++) begin
      if (i_spike || i_mask[k]) w_or = w_or | i_slice_rdata[32*k +: 32];
    end
    if (i_tmo)     o_rdata = 32'hFFFF_FFFF;
    else if (i_cw) o_rdata = {26'b0, i_weight_sel};
    else           o_rdata = w_or;
  end

endmodule

// File: rtl/core_wb_seq.sv
// Wishbone slave sequencer fanning requests out to neuron-core slices.
// Optional WAIT timeout with forced ack and sticky err_o: CORE_WB_SEQ_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for cyc&stb, latches the request
// S_DECODE | external decoder settles on the latched address; flags registered
// S_ACCESS | one-cycle slice_en_o strobe
// S_WAIT   | waiting for all selected slices ready (or timeout)
// S_ACK    | one-cycle wbs_ack_o with read data / side effects
module core_wb_seq #(
  parameter int          NUM_OF_SLICE = 8,
  parameter logic [7:0]  ACK_TIMEOUT  = 8'd255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  core_wb_seq_if.slave               wb,
  output logic [31:0]                dec_addr_o,
  output logic                       dec_we_o,
  input  logic [NUM_OF_SLICE-1:0]    dec_slice_i,
  input  logic                       dec_send_spike_i,
  input  logic                       dec_choose_weight_i,
  input  logic                       dec_picture_done_i,
  output logic [NUM_OF_SLICE-1:0]    slice_en_o,
  output logic                       slice_we_o,
  output logic [31:0]                slice_wdata_o,
  output logic [3:0]                 slice_sel_o,
  input  logic [32*NUM_OF_SLICE-1:0] slice_rdata_i,
  input  logic [NUM_OF_SLICE-1:0]    slice_ready_i,
  output logic [5:0]                 weight_sel_o,
  output logic                       pic_done_o,
  output logic                       err_o
);

  import core_pkg::*;

  localparam logic [7:0] TMO_LOAD = ACK_TIMEOUT - 8'd1;

  state_t                  r_state, w_next;
  logic [31:0]             r_adr, r_wdata;
  logic                    r_we;
  logic [3:0]              r_sel;
  logic [NUM_OF_SLICE-1:0] r_mask, r_rdy;
  logic                    r_spike, r_cw, r_pd;
  logic [7:0]              r_cnt;
  logic                    r_tmo_hit, r_err;
  logic [5:0]              r_weight_sel;
  logic                    w_ready_all, w_tmo_fire, w_timeout;
  logic [31:0]             w_rdata;

  // Readiness seen during ACCESS is remembered so a short ready pulse still counts.
  assign w_ready_all = (((slice_ready_i | r_rdy) & r_mask) == r_mask);

`ifdef CORE_WB_SEQ_TIMEOUT_EN
  assign w_tmo_fire = (r_cnt == 8'd0);
`else
  assign w_tmo_fire = 1'b0;
`endif

  assign w_timeout = (r_state == S_WAIT) && wb.wbs_cyc_i && !w_ready_all && w_tmo_fire;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= S_IDLE;
      r_adr        <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_mask       <= '0;
      r_rdy        <= '0;
      r_spike      <= 1'b0;
      r_cw         <= 1'b0;
      r_pd         <= 1'b0;
      r_cnt        <= '0;
      r_tmo_hit    <= 1'b0;
      r_err        <= 1'b0;
      r_weight_sel <= '0;
    end else begin
      r_state   <= w_next;
      r_tmo_hit <= w_timeout;
      if (w_timeout) r_err <= 1'b1;
      if (r_state == S_IDLE && wb.wbs_cyc_i && wb.wbs_stb_i) begin
        r_adr   <= wb.wbs_adr_i;
        r_wdata <= wb.wbs_dat_i;
        r_we    <= wb.wbs_we_i;
        r_sel   <= wb.wbs_sel_i;
      end
      if (r_state == S_DECODE) begin
        r_mask  <= dec_slice_i;
        r_spike <= dec_send_spike_i;
        r_cw    <= dec_choose_weight_i;
        r_pd    <= dec_picture_done_i;
      end
      if (r_state == S_ACCESS || r_state == S_WAIT) r_rdy <= r_rdy | (slice_ready_i & r_mask);
      else                                          r_rdy <= '0;
      if (r_state == S_ACCESS)                      r_cnt <= TMO_LOAD;
      else if (r_state == S_WAIT && r_cnt != 8'd0)  r_cnt <= r_cnt - 8'd1;
      // Weight index becomes visible together with the ack of the write.
      if (r_state == S_DECODE && w_next == S_ACK && dec_choose_weight_i && r_we)
        r_weight_sel <= r_adr[5:0];
    end
  end

  always_comb begin
    w_next        = r_state;
    wb.wbs_ack_o  = 1'b0;
    wb.wbs_dat_o  = '0;
    slice_en_o    = '0;
    pic_done_o    = 1'b0;
    case (r_state)
      S_IDLE:   if (wb.wbs_cyc_i && wb.wbs_stb_i) w_next = S_DECODE;
      S_DECODE: begin
        if (!wb.wbs_cyc_i)      w_next = S_IDLE;
        else if (|dec_slice_i)  w_next = S_ACCESS;
        else                    w_next = S_ACK;
      end
      S_ACCESS: begin
        slice_en_o = r_mask;
        w_next     = wb.wbs_cyc_i ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!wb.wbs_cyc_i)                 w_next = S_IDLE;
        else if (w_ready_all || w_tmo_fire) w_next = S_ACK;
      end
      S_ACK: begin
        wb.wbs_ack_o = 1'b1;
        wb.wbs_dat_o = w_rdata;
        pic_done_o   = r_pd && r_we;
        w_next       = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  core_rdata_mux #(.NUM_OF_SLICE(NUM_OF_SLICE)) u_rdata_mux (
    .i_slice_rdata (slice_rdata_i),
    .i_mask        (r_mask),
    .i_spike       (r_spike),
    .i_cw          (r_cw),
    .i_tmo         (r_tmo_hit),
    .i_weight_sel  (r_weight_sel),
    .o_rdata       (w_rdata)
  );

  assign dec_addr_o    = r_adr;
  assign dec_we_o      = r_we;
  assign slice_we_o    = r_we;
  assign slice_wdata_o = r_wdata;
  assign slice_sel_o   = r_sel;
  assign weight_sel_o  = r_weight_sel;
  assign err_o         = r_err;

endmodule

// File: tb/tb_core_wb_seq.sv
// Directed bench for core_wb_seq with a behavioural address decoder.
module tb_core_wb_seq;
  import core_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_wb_seq_if wb();

  logic [31:0]    dec_addr;
  logic           dec_we;
  logic [N-1:0]   dslice;
  logic           dspike, dcw, dpd;
  logic [N-1:0]   slice_en;
  logic           slice_we;
  logic [31:0]    slice_wdata;
  logic [3:0]     slice_sel;
  logic [32*N-1:0] rdata;
  logic [N-1:0]   ready;
  logic [5:0]     wsel;
  logic           pd, err;

  core_wb_seq #(.NUM_OF_SLICE(N), .ACK_TIMEOUT(8'd255)) dut (
    .wb_clk_i            (clk),
    .wb_rst_ni           (rst_n),
    .wb                  (wb),
    .dec_addr_o          (dec_addr),
    .dec_we_o            (dec_we),
    .dec_slice_i         (dslice),
    .dec_send_spike_i    (dspike),
    .dec_choose_weight_i (dcw),
    .dec_picture_done_i  (dpd),
    .slice_en_o          (slice_en),
    .slice_we_o          (slice_we),
    .slice_wdata_o       (slice_wdata),
    .slice_sel_o         (slice_sel),
    .slice_rdata_i       (rdata),
    .slice_ready_i       (ready),
    .weight_sel_o        (wsel),
    .pic_done_o          (pd),
    .err_o               (err)
  );

  localparam logic [25:0] CW_TAG = 26'(CHOOSE_WEIGHT_BASE >> 6);

  always_comb begin
    dslice = '0;
    dspike = 1'b0;
    dcw    = 1'b0;
    dpd    = 1'b0;
    if (dec_addr == DONE_PIC_ADDR)         dpd = 1'b1;
    else if (dec_addr[31:6] == CW_TAG)     dcw = 1'b1;
    else if (dec_addr == 32'h3000_0000) begin
      dspike = 1'b1;
      dslice = '1;
    end else if (dec_addr[31:16] == 16'h3000 && dec_addr[15:12] != 4'd0)
      dslice = N'(1) << dec_addr[14:12];
  end

  int n_chk = 0;
  int n_bad = 0;
  int lat, en_cyc, pd_cnt, ack_cnt;
  logic [N-1:0] en_or;
  logic pd_at_ack, got_ack, ack_after;
  logic [31:0] rdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req_on(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel);
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
  endtask

  task automatic req_off();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  // lat counts edges from the accepting edge to the edge that samples ack.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input logic [3:0] sel, input int budget);
    en_or = '0; en_cyc = 0; pd_cnt = 0; got_ack = 1'b0; lat = 0; rdat = '0; pd_at_ack = 1'b0;
    req_on(adr, dat, we, sel);
    @(posedge clk); #1;
    for (int n = 1; n <= budget && !got_ack; n++) begin
      @(posedge clk); #1;
      en_or = en_or | slice_en;
      if (slice_en != '0) en_cyc++;
      if (pd) pd_cnt++;
      if (wb.wbs_ack_o) begin
        got_ack   = 1'b1;
        lat       = n + 1;
        rdat      = wb.wbs_dat_o;
        pd_at_ack = pd;
      end
    end
    req_off();
    @(posedge clk); #1;
    ack_after = wb.wbs_ack_o;
    if (pd) pd_cnt++;
  endtask

  task automatic watch(input int n);
    ack_cnt = 0; pd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) ack_cnt++;
      if (pd) pd_cnt++;
    end
  endtask

  initial begin
    logic hit;
    req_off();
    wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    for (int k = 0; k < N; k++) rdata[32*k +: 32] = 32'(1) << k;
    ready = '1;

    #12;
    chk("rst_ack", 32'(wb.wbs_ack_o), 0);
    chk("rst_en", 32'(slice_en), 0);
    chk("rst_wsel", 32'(wsel), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk); rst_n = 1'b1;

    xfer(32'h3000_3010, 32'hA5A5_0001, 1'b1, 4'h3, 20);
    chk("wr3_ack", 32'(got_ack), 1);
    chk("wr3_lat", 32'(lat), 4);
    chk("wr3_en", 32'(en_or), 32'h08);
    chk("wr3_encyc", 32'(en_cyc), 1);
    chk("wr3_wdata", slice_wdata, 32'hA5A5_0001);
    chk("wr3_sel", 32'(slice_sel), 32'h3);
    chk("wr3_we", 32'(slice_we), 1);
    chk("wr3_ack1", 32'(ack_after), 0);

    xfer(32'h3000_0000, 32'h0, 1'b0, 4'hF, 20);
    chk("bc_en", 32'(en_or), 32'hFF);
    chk("bc_dat", rdat, 32'h0000_00FF);
    chk("bc_lat", 32'(lat), 4);

    xfer(32'h3000_3000, 32'h0, 1'b0, 4'hF, 20);
    chk("rd3_dat", rdat, 32'h0000_0008);

    xfer(DONE_PIC_ADDR, 32'h1, 1'b1, 4'hF, 20);
    chk("pd_lat", 32'(lat), 2);
    chk("pd_encyc", 32'(en_cyc), 0);
    chk("pd_at_ack", 32'(pd_at_ack), 1);
    chk("pd_cnt", 32'(pd_cnt), 1);

    xfer(DONE_PIC_ADDR, 32'h0, 1'b0, 4'hF, 20);
    chk("pdrd_cnt", 32'(pd_cnt), 0);
    chk("pdrd_dat", rdat, 0);

    xfer(32'h3000_0815, 32'h0, 1'b1, 4'hF, 20);
    chk("cw_lat", 32'(lat), 2);
    chk("cw_wsel", 32'(wsel), 32'h15);
    xfer(32'h3000_0815, 32'h0, 1'b0, 4'hF, 20);
    chk("cwrd_dat", rdat, 32'h15);
    xfer(32'h3000_0822, 32'h0, 1'b0, 4'hF, 20);
    chk("cwrd2_wsel", 32'(wsel), 32'h15);

    // ready pulses only while the slice strobe is up
    ready = '0;
    hit = 1'b0;
    fork
      xfer(32'h3000_3000, 32'h0, 1'b0, 4'hF, 10);
      begin
        for (int i = 0; i < 8 && !hit; i++) begin
          @(negedge clk);
          if (slice_en != '0) begin
            hit = 1'b1;
            ready = slice_en;
            @(negedge clk);
            ready = '0;
          end
        end
      end
    join
    chk("pulse_ack", 32'(got_ack), 1);
    chk("pulse_lat", 32'(lat), 4);

`ifdef CORE_WB_SEQ_TIMEOUT_EN
    xfer(32'h3000_5000, 32'h0, 1'b0, 4'hF, 400);
    chk("tmo_ack", 32'(got_ack), 1);
    chk("tmo_lat", 32'(lat), 258);
    chk("tmo_en", 32'(en_or), 32'h20);
    chk("tmo_dat", rdat, 32'hFFFF_FFFF);
    chk("tmo_err", 32'(err), 1);
`else
    req_on(32'h3000_5000, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    watch(300);
    chk("hold_ack", 32'(ack_cnt), 0);
    chk("hold_err", 32'(err), 0);
    req_off();
    watch(3);
`endif

    req_on(32'h3000_5000, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    watch(20);
    req_off();
    watch(5);
    chk("abort_wait_ack", 32'(ack_cnt), 0);

    req_on(32'h3000_0833, 32'h0, 1'b1, 4'hF);
    @(posedge clk); #1;
    req_off();
    watch(5);
    chk("abort_cw_ack", 32'(ack_cnt), 0);
    chk("abort_cw_wsel", 32'(wsel), 32'h15);

    req_on(DONE_PIC_ADDR, 32'h0, 1'b1, 4'hF);
    @(posedge clk); #1;
    req_off();
    watch(5);
    chk("abort_pd_cnt", 32'(pd_cnt), 0);

    req_on(32'h3000_5000, 32'h1234_5678, 1'b1, 4'hF);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_ack", 32'(wb.wbs_ack_o), 0);
    chk("mrst_addr", dec_addr, 0);
    chk("mrst_wdata", slice_wdata, 0);
    chk("mrst_wsel", 32'(wsel), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_en", 32'(slice_en), 0);
    req_off();
    @(negedge clk); rst_n = 1'b1;
    ready = '1;
    xfer(32'h3000_3010, 32'hA5A5_0002, 1'b1, 4'hF, 20);
    chk("post_rst_ack", 32'(got_ack), 1);
    chk("post_rst_lat", 32'(lat), 4);
    chk("post_rst_en", 32'(en_or), 32'h08);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/core_wb_seq.md
CORE_WB_SEQ -- requirements
Module: core_wb_seq

Interface
REQ-001 SHALL have parameter NUM_OF_SLICE, default 8, number of neuron-core slices.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, maximum WAIT cycles before a forced ack; 8-bit.
REQ-003 SHALL have port wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone classic slave request.
REQ-006 SHALL have port wbs_sel_i  in  4  byte lanes, forwarded as slice_sel_o.
REQ-007 SHALL have port wbs_adr_i / wbs_dat_i  in  32 each  request address and write data.
REQ-008 SHALL have port wbs_ack_o  out  1  one-cycle acknowledge.
REQ-009 SHALL have port wbs_dat_o  out  32  read data, valid with ack.
REQ-010 SHALL have port dec_addr_o / dec_we_o  out  32 / 1  latched address and we to the address decoder.
REQ-011 SHALL have port dec_slice_i  in  NUM_OF_SLICE  decoder slice selects; dec_send_spike_i, dec_choose_weight_i, dec_picture_done_i  in  1 each.
REQ-012 SHALL have port slice_en_o  out  NUM_OF_SLICE  one-cycle access strobe per slice.
REQ-013 SHALL have port slice_we_o / slice_wdata_o / slice_sel_o  out  1 / 32 / 4  latched request.
REQ-014 SHALL have port slice_rdata_i  in  32*NUM_OF_SLICE  packed read data, slice k at [32k+31:32k].
REQ-015 SHALL have port slice_ready_i  in  NUM_OF_SLICE  per-slice completion.
REQ-016 SHALL have port weight_sel_o  out  6  registered choose_weight index (adr[5:0]); pic_done_o  out  1  one-cycle pulse; err_o  out  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM IDLE, DECODE, ACCESS, WAIT, ACK.
REQ-018 IDLE: on cyc&stb SHALL latch adr, dat, we, sel into dec_addr_o / slice_* registers and go to DECODE; no new request accepted outside IDLE.
REQ-019 DECODE: SHALL register decoder outputs; any slice bit set -> ACCESS, else -> ACK.
REQ-020 ACCESS: SHALL drive slice_en_o = registered slice mask for exactly one cycle, then go to WAIT.
REQ-021 WAIT: SHALL go to ACK when (slice_ready_i & mask) == mask.
REQ-022 ACK: SHALL assert wbs_ack_o one cycle, then return to IDLE; minimum latency is ack 4 cycles after accepting edge (slice) or 2 cycles (non-slice).
REQ-023 Read data: single slice -> that slice's word; send_spike broadcast -> bitwise OR of all slice words; choose_weight read -> {26'b0, weight_sel_o}; otherwise 0.
REQ-024 choose_weight write SHALL update weight_sel_o in ACK cycle; picture_done write SHALL pulse pic_done_o in ACK cycle; reads of either have no side effect.
REQ-025 cyc_i deasserted in DECODE/ACCESS/WAIT SHALL abort to IDLE with no ack, no pic_done_o pulse, weight_sel_o unchanged.
REQ-026 slice_ready_i arriving during ACCESS SHALL be honoured on first WAIT cycle (no extra latency).

Reset
REQ-027 Reset low SHALL asynchronously force IDLE, all outputs 0, weight_sel_o 0, err_o 0, timeout counter 0; mid-transaction reset drops the transaction without ack.

Configuration
REQ-028 With CORE_WB_SEQ_TIMEOUT_EN defined, WAIT lasting ACK_TIMEOUT cycles SHALL go to ACK with wbs_dat_o = 32'hFFFF_FFFF and set err_o (cleared only by reset).
REQ-029 Without CORE_WB_SEQ_TIMEOUT_EN, WAIT SHALL hold indefinitely and err_o SHALL be tied 0.

Structure
REQ-030 State encoding, NUM_OF_SLICE, DONE_PIC_ADDR 32'h3000_0840 and CHOOSE_WEIGHT_BASE 32'h3000_0800 SHALL live in a shared package core_pkg.
REQ-031 The read-data merge SHALL be one sub-module core_rdata_mux; the decoder is instantiated outside, not inside.

Verification
REQ-032 Write 0x3000_3010 data 0xA5A5_0001, ready held high -> slice_en_o=8'h08 one cycle, ack at cycle 4, slice_wdata_o=0xA5A5_0001.
REQ-033 Read 0x3000_0000 (broadcast), slice words 0x1,0x2,...,0x80 -> slice_en_o=8'hFF, wbs_dat_o=0x0000_00FF.
REQ-034 Write 0x3000_0840 -> no slice_en, pic_done_o one pulse coincident with ack at cycle 2.
REQ-035 Write 0x3000_0815 then read 0x3000_0815 -> weight_sel_o=6'h15, read data 0x15.
REQ-036 Slice 5 access, ready never asserts, macro defined -> ack after 255 WAIT cycles, data 0xFFFF_FFFF, err_o=1; cyc dropped in WAIT instead -> IDLE, no ack.
REQ-037 wb_rst_ni low during WAIT -> immediate IDLE, all outputs 0, next request served normally.
